fetch_unit: RTL and testbench

Instruction fetch stage for the single-cycle RISC-V core. It sits directly upstream of the control path and holds the PC register. It issues in-order requests to the instruction memory, buffers the returned words with their PCs, and presents them to decode through a valid/ready handshake. It also consumes the control path's `PCSrc` redirect: on a redirect it flushes the buffer and restarts fetch at the branch target.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with occupancy count and single-cycle flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, credit-limited imem requests, buffered decode handoff.
// Define FETCH_PERF_EN to add the FetchCount / FlushCount performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        ImemReqValid,
  input  logic        ImemReqReady,
  output logic [31:0] ImemAddr,
  input  logic        ImemRspValid,
  input  logic [31:0] ImemRspData,
  output logic        InstValid,
  input  logic        InstReady,
  output logic [31:0] Instruction,
  output logic [31:0] InstPC,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] FlushCount
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t  state, state_next;
  logic [31:0]   pc, pc_next;
  logic [CW-1:0] drop_cnt, drop_next;
  logic [CW-1:0] inflight;
  logic [CW-1:0] occupancy;
  logic [CW:0]   pending;
  logic          req_fire;
  logic          redirect;
  logic          rsp_keep;
  logic          pop_raw;
  logic          pop_ok;
  fetch_entry_t  pcq_in, pcq_head;
  fetch_entry_t  buf_in, buf_head;

  assign redirect = PCSrc && (state != BOOT);
  assign pop_raw  = InstValid && InstReady;
  assign pop_ok   = pop_raw && !redirect;
  assign rsp_keep = ImemRspValid && (drop_cnt == '0) && !redirect;

  // A decode pop this cycle frees its slot, which sustains one fetch per cycle.
  assign pending      = (CW+1)'(inflight) + (CW+1)'(occupancy) - (CW+1)'(pop_raw);
  assign ImemReqValid = (state == RUN) && (pending < (CW+1)'(FIFO_DEPTH));
  assign req_fire     = ImemReqValid && ImemReqReady;

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    drop_next  = drop_cnt;
    if (req_fire) pc_next = pc + 32'd4;
    if (ImemRspValid && (drop_cnt != '0)) drop_next = drop_cnt - 1'b1;
    if (redirect) begin
      pc_next   = BranchTarget & ~32'h3;
      drop_next = inflight + CW'(req_fire) - CW'(ImemRspValid);
    end
    case (state)
      BOOT:       state_next = RUN;
      RUN, DRAIN: state_next = (drop_next != '0) ? DRAIN : RUN;
      default:    state_next = BOOT;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      drop_cnt <= drop_next;
    end
  end

  assign pcq_in = '{instr: NOP_INSTR, pc: pc};

  always_comb begin
    buf_in       = pcq_head;
    buf_in.instr = ImemRspData;
  end

  // Responses return in order, so the PC queue head always names the arriving word.
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk       (CLK),
    .rst       (RESET),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pcq_in),
    .pop       (ImemRspValid),
    .head      (pcq_head),
    .count     (inflight)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_inst_buf (
    .clk       (CLK),
    .rst       (RESET),
    .flush     (redirect),
    .push      (rsp_keep),
    .push_data (buf_in),
    .pop       (pop_raw),
    .head      (buf_head),
    .count     (occupancy)
  );

  assign ImemAddr    = pc;
  assign InstValid   = (occupancy != '0);
  assign Instruction = InstValid ? buf_head.instr : NOP_INSTR;
  assign InstPC      = InstValid ? buf_head.pc : RESET_PC;

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FetchCount <= '0;
      FlushCount <= '0;
    end else begin
      if (pop_ok)   FetchCount <= FetchCount + 32'd1;
      if (redirect) FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory of configurable latency.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC   = 32'h0000_0100;
  localparam int          FIFO_DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ImemReqValid;
  logic        ImemReqReady = 1'b1;
  logic [31:0] ImemAddr;
  logic        ImemRspValid = 1'b0;
  logic [31:0] ImemRspData = 32'h0;
  logic        InstValid;
  logic        InstReady = 1'b1;
  logic [31:0] Instruction;
  logic [31:0] InstPC;
  logic        PCSrc = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
`ifdef FETCH_PERF_EN
  logic [31:0] FetchCount;
  logic [31:0] FlushCount;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ImemReqValid (ImemReqValid),
    .ImemReqReady (ImemReqReady),
    .ImemAddr     (ImemAddr),
    .ImemRspValid (ImemRspValid),
    .ImemRspData  (ImemRspData),
    .InstValid    (InstValid),
    .InstReady    (InstReady),
    .Instruction  (Instruction),
    .InstPC       (InstPC),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget)
`ifdef FETCH_PERF_EN
    ,
    .FetchCount   (FetchCount),
    .FlushCount   (FlushCount)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    mem_q[$];
  int          mem_lat = 1;
  int          cyc = 0;
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] pc_log[$];
  logic [31:0] ins_log[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory and handshake monitor: sample at the active edge, before the DUT updates.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RESET) begin
      mem_q.delete();
    end else begin
      if (ImemRspValid && mem_q.size() > 0) void'(mem_q.pop_front());
      if (ImemReqValid && ImemReqReady) begin
        mem_q.push_back('{addr: ImemAddr, due: cyc + mem_lat});
        req_log.push_back(ImemAddr);
        req_cyc.push_back(cyc);
      end
      if (InstValid && InstReady && !PCSrc) begin
        pc_log.push_back(InstPC);
        ins_log.push_back(Instruction);
      end
    end
  end

  // Returned word is the bitwise inverse of its address.
  always @(negedge CLK) begin
    if (!RESET && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      ImemRspValid = 1'b1;
      ImemRspData  = ~mem_q[0].addr;
    end else begin
      ImemRspValid = 1'b0;
      ImemRspData  = 32'h0;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic wait_pops(input int n, input string tag);
    int k = 0;
    while (pc_log.size() < n && k < 100) begin
      step();
      k++;
    end
    check(tag, 32'(pc_log.size() >= n), 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_valid"}, ImemReqValid, 1'b0);
    check({pfx, "_addr"}, ImemAddr, RESET_PC);
    check({pfx, "_inst_valid"}, InstValid, 1'b0);
    check({pfx, "_instr"}, Instruction, NOP_INSTR);
    check({pfx, "_inst_pc"}, InstPC, RESET_PC);
`ifdef FETCH_PERF_EN
    check({pfx, "_fetch_count"}, FetchCount, 32'd0);
    check({pfx, "_flush_count"}, FlushCount, 32'd0);
`endif
  endtask

  initial begin
    int max_out;
    int n_req;
    int found;
    int r;
    int n0;
    int q0;

    // Reset state
    step(3);
    check_reset_outputs("reset");

    // Boot cycle, then back-to-back fetch from RESET_PC
    RESET = 1'b0;
    #1;
    check("boot_no_req", ImemReqValid, 1'b0);
    step();
    check("first_req_valid", ImemReqValid, 1'b1);
    check("first_req_addr", ImemAddr, 32'h100);
    wait_pops(3, "seq_timeout");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("seq_req%0d", i), req_log[i], 32'h100 + 32'(4 * i));
      check($sformatf("seq_pc%0d", i), pc_log[i], 32'h100 + 32'(4 * i));
      check($sformatf("seq_ins%0d", i), ins_log[i], ~(32'h100 + 32'(4 * i)));
    end
    check("seq_gap01", 32'(req_cyc[1] - req_cyc[0]), 32'd1);
    check("seq_gap12", 32'(req_cyc[2] - req_cyc[1]), 32'd1);

    // Decode stall: credits stop requests once buffer plus in-flight is full
    InstReady = 1'b0;
    max_out = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (req_log.size() - pc_log.size() > max_out) max_out = req_log.size() - pc_log.size();
    end
    check("stall_max_out", 32'(max_out), 32'(FIFO_DEPTH));
    check("stall_held", 32'(req_log.size() - pc_log.size()), 32'(FIFO_DEPTH));
    n_req = req_log.size();
    InstReady = 1'b1;
    wait_pops(n_req, "stall_release_timeout");
    for (int i = 3; i < n_req; i++)
      check($sformatf("stall_order%0d", i), pc_log[i], 32'h100 + 32'(4 * i));

    // Memory back-pressure holds the request address
    ImemReqReady = 1'b0;
    step(3);
    check("bp_valid", ImemReqValid, 1'b1);
    check("bp_addr", ImemAddr, 32'h100 + 32'(4 * req_log.size()));
    step();
    check("bp_addr_hold", ImemAddr, 32'h100 + 32'(4 * req_log.size()));
    ImemReqReady = 1'b1;

    // Redirect with two requests in flight and an empty buffer
    mem_lat = 3;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (mem_q.size() == 2 && !ImemRspValid && !InstValid) begin
        found = 1;
        break;
      end
    end
    check("rd2_sync", 32'(found), 32'd1);
    r = cyc; n0 = pc_log.size(); q0 = req_log.size();
    PCSrc = 1'b1; BranchTarget = 32'h203;
    step();
    PCSrc = 1'b0;
    check("rd2_inst_valid", InstValid, 1'b0);
    check("rd2_req_valid", ImemReqValid, 1'b0);
    check("rd2_addr", ImemAddr, 32'h200);
    wait_pops(n0 + 1, "rd2_timeout");
    check("rd2_pc", pc_log[n0], 32'h200);
    check("rd2_ins", ins_log[n0], ~32'h200);
    check("rd2_req", req_log[q0], 32'h200);
    check("rd2_req_cyc", 32'(req_cyc[q0]), 32'(r + 3));

    // Redirect coinciding with a response and a request handshake
    mem_lat = 1;
    step(8);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (ImemRspValid && ImemReqValid && InstValid) begin
        found = 1;
        break;
      end
      step();
    end
    check("rd1_sync", 32'(found), 32'd1);
    r = cyc; n0 = pc_log.size(); q0 = req_log.size();
    PCSrc = 1'b1; BranchTarget = 32'h400;
    step();
    PCSrc = 1'b0;
    check("rd1_inst_valid", InstValid, 1'b0);
    check("rd1_req_valid", ImemReqValid, 1'b0);
    check("rd1_addr", ImemAddr, 32'h400);
    wait_pops(n0 + 1, "rd1_timeout");
    check("rd1_pc", pc_log[n0], 32'h400);
    check("rd1_req", req_log[q0 + 1], 32'h400);
    check("rd1_req_cyc", 32'(req_cyc[q0 + 1]), 32'(r + 2));

    // PC wraps from the top of the address space
    step(4);
    n0 = pc_log.size();
    PCSrc = 1'b1; BranchTarget = 32'hFFFF_FFFF;
    step();
    PCSrc = 1'b0;
    wait_pops(n0 + 2, "wrap_timeout");
    check("wrap_pc0", pc_log[n0], 32'hFFFF_FFFC);
    check("wrap_pc1", pc_log[n0 + 1], 32'h0000_0000);
    check("wrap_ins1", ins_log[n0 + 1], 32'hFFFF_FFFF);

    // Asynchronous reset while draining
    mem_lat = 4;
    step(6);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (mem_q.size() > 0 && !ImemRspValid) begin
        found = 1;
        break;
      end
      step();
    end
    check("drain_sync", 32'(found), 32'd1);
    PCSrc = 1'b1; BranchTarget = 32'h800;
    step();
    PCSrc = 1'b0;
    check("drain_req_valid", ImemReqValid, 1'b0);
    check("drain_addr", ImemAddr, 32'h800);
`ifdef FETCH_PERF_EN
    check("perf_fetch", FetchCount, 32'(pc_log.size()));
    check("perf_flush", FlushCount, 32'd4);
`endif
    #2;
    RESET = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    step(2);
    mem_lat = 1;
    n0 = pc_log.size();
    RESET = 1'b0;
    #1;
    check("reboot_no_req", ImemReqValid, 1'b0);
    step();
    check("reboot_req_valid", ImemReqValid, 1'b1);
    check("reboot_addr", ImemAddr, RESET_PC);
    wait_pops(n0 + 1, "reboot_timeout");
    check("reboot_pc", pc_log[n0], RESET_PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
